fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//  Downstream of the output data mux. Accepts 16-point FFT results as 4 beats of 4 complex samples
//  (136-bit bus), emitted in bit-reversed index order. Reorders them into natural order through a
//  ping-pong pair of 16-entry sample banks. Streams each frame out as 4 natural-order beats with valid/ready.
// PARAMETERS
//  SAMPLE_W  34  bits per complex sample: {re[16:0], im[16:0]}
//  LANES     4   samples per beat; fixed at 4 for NPOINT=16
//  NPOINT    16  FFT length; BEATS = NPOINT/LANES = 4
// PORTS
//  clk       in   1    single clock; all state on posedge
//  rst       in   1    synchronous, active-high reset
//  in_valid  in   1    input beat valid
//  in_sop    in   1    marks beat 0 of a frame
//  in_data   in   136  lane l at bits [34*l+33:34*l]
//  in_ready  out  1    beat accepted when in_valid & in_ready
//  out_valid out  1    output beat valid
//  out_ready in   1    downstream accept
//  out_data  out  136  natural-order beat; lane j at bits [34*j+33:34*j]
//  out_last  out  1    high on output beat 3 of a frame
//  err_sync  out  1    1-cycle pulse on a framing error
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, out_data=0, out_last=0, err_sync=0; wr_sel=rd_sel=0,
//    full[1:0]=0, wr_beat=rd_beat=0. Bank contents are not reset.
//  - Index map: input beat b, lane l holds natural index n = bitrev4(4*b+l).
//    It is written to bank[wr_sel][n]. Beat 0 lanes therefore carry n = 0,8,4,12.
//  - in_ready = !full[wr_sel].
//  - Accept with wr_beat==0 and !in_sop: beat dropped, err_sync pulses.
//  - Accept with in_sop and wr_beat!=0: partial frame discarded, err_sync pulses.
//    The beat is then written as beat 0, and wr_beat becomes 1.
//  - 4th accepted beat (wr_beat==3): full[wr_sel]<=1, wr_sel toggles, wr_beat<=0.
//  - out_valid = full[rd_sel]. Output latency: out_valid is high the cycle after the 4th input beat
//    is accepted, provided the read bank is free.
//  - out_data = bank[rd_sel][4*rd_beat+j] for lane j when out_valid, else 0. out_last = out_valid & (rd_beat==3).
//  - Output accept: rd_beat increments. On rd_beat==3: full[rd_sel]<=0, rd_sel toggles, rd_beat<=0.
//  - out_data, out_last and rd_beat hold while out_valid & !out_ready.
//  - Simultaneous final write and final read always target different banks; both updates apply in the same cycle.
//    A bank freed this cycle is writable next cycle (no combinational ready path).
//  - Both banks full: in_ready=0 until the read side frees a bank. No data is lost or overwritten.
//  - rst mid-frame or mid-readout: everything returns to reset values next cycle. Partial and pending frames are discarded.
// CONFIGURATION
//  - FFT_REORDER_FRAMECNT_EN defined: adds port frame_cnt out 16.
//    It counts frames fully read out (accepted out_last), resets to 0, and wraps 16'hFFFF->0.
//  - Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared package fft_pkg: SAMPLE_W, LANES, NPOINT, BEATS constants.
//  - fft_pkg also holds the sample typedef {re,im} and the bitrev4 function.
//  - Sub-module fft_reorder_bank holds 16 x SAMPLE_W registers, with 4 write lanes (index, data, enable)
//    and a 4-lane read of one beat. Instantiated twice (ping/pong).
//  - Top level holds the sel/full/beat control and framing checks.
// TESTING (each sample data = its natural index, re=im=n)
//  1. Hold rst 2 cycles -> in_ready=1, out_valid=0, out_data=0, err_sync=0.
//  2. One frame, in_sop on beat 0, out_ready=1 -> out_valid the cycle after beat 3.
//     Output beats are {3,2,1,0},{7,6,5,4},{11..8},{15..12} (lane3..lane0), and out_last is high on beat 3 only.
//  3. Three back-to-back frames, out_ready=0 -> in_ready=0 after frame 2. Then raise out_ready
//     -> frames 1,2,3 come out intact and in order, with no beat duplicated.
//  4. in_sop again at wr_beat=2 -> err_sync=1 for one cycle, partial frame discarded,
//     and the following frame is reordered correctly. Beat without in_sop at wr_beat=0 -> dropped, err_sync pulse.
//  5. rst at input beat 2, then again during output beat 1 -> next cycle out_valid=0 and in_ready=1;
//     the next full frame comes out correctly.
//  6. With FFT_REORDER_FRAMECNT_EN: 3 frames read -> frame_cnt=3. Force 16'hFFFF then 1 frame -> frame_cnt=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT output reorder path.
//   SAMPLE_W/LANES/NPOINT/BEATS : geometry of the sample stream
//   sample_t                    : one complex sample {re, im}
//   beat_t                      : one bus beat of LANES samples (lane 0 in the low bits)
//   bitrev4()                   : 4-bit index bit reversal
package fft_pkg;

    localparam int SAMPLE_W = 34;
    localparam int LANES    = 4;
    localparam int NPOINT   = 16;
    localparam int BEATS    = NPOINT / LANES;
    localparam int IDX_W    = 4;
    localparam int BEAT_W   = 2;

    typedef struct packed {
        logic [16:0] re;
        logic [16:0] im;
    } sample_t;

    typedef logic [LANES-1:0][SAMPLE_W-1:0] beat_t;

    function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One 16-entry sample bank of the reorder ping-pong pair.
// Ports:
//   clk       : clock (contents are not reset)
//   wr_en_i   : per-lane write enable
//   wr_idx_i  : per-lane natural-order destination index
//   wr_data_i : per-lane write data (one full beat)
//   rd_beat_i : output beat number; lane j reads entry 4*rd_beat_i + j
//   rd_data_o : four consecutive natural-order samples
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic                        clk,
    input  logic [LANES-1:0]            wr_en_i,
    input  logic [LANES-1:0][IDX_W-1:0] wr_idx_i,
    input  beat_t                       wr_data_i,
    input  logic [BEAT_W-1:0]           rd_beat_i,
    output beat_t                       rd_data_o
);

    sample_t ent_arr [NPOINT];

    for (genvar e = 0; e < NPOINT; e++) begin : g_ent
        sample_t ent_q;
        sample_t ent_d;
        logic    hit;

        // Lanes of one beat always target distinct indices, so at most one hits.
        always_comb begin
            hit   = 1'b0;
            ent_d = ent_q;
            for (int l = 0; l < LANES; l++) begin
                if (wr_en_i[l] && (wr_idx_i[l] == IDX_W'(e))) begin
                    hit   = 1'b1;
                    ent_d = sample_t'(wr_data_i[l]);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (hit) begin
                ent_q <= ent_d;
            end
        end

        assign ent_arr[e] = ent_q;
    end

    always_comb begin
        rd_data_o = '0;
        for (int j = 0; j < LANES; j++) begin
            rd_data_o[j] = ent_arr[{rd_beat_i, BEAT_W'(j)}];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Reorders 16-point FFT results from bit-reversed to natural order through
// a ping-pong pair of sample banks, and streams frames out with valid/ready.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_sop marks beat 0 of a frame
//   in_data             : 4 bit-reversed samples, lane l at [34*l +: 34]
//   out_valid/out_ready : output handshake
//   out_data            : 4 natural-order samples, lane j at [34*j +: 34]
//   out_last            : high on the final beat of a frame
//   err_sync            : one-cycle pulse after a framing error
//   frame_cnt           : frames fully read out (only with FFT_REORDER_FRAMECNT_EN)
// Optional feature macro: FFT_REORDER_FRAMECNT_EN
module fft_out_reorder
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sop,
    input  logic [LANES*SAMPLE_W-1:0] in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*SAMPLE_W-1:0] out_data,
    output logic                      out_last,
    output logic                      err_sync
`ifdef FFT_REORDER_FRAMECNT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [1:0]        full_q, full_d;
    logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
    logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
    logic              err_q, err_d;

    logic              wr_fire, rd_fire, drop, restart, wr_ok;
    logic [BEAT_W-1:0] eff_beat;

    assign in_ready  = !full_q[wr_sel_q];
    assign out_valid = full_q[rd_sel_q];
    assign out_last  = out_valid && (rd_beat_q == LAST_BEAT);
    assign err_sync  = err_q;

    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = out_valid && out_ready;
    assign drop     = !in_sop && (wr_beat_q == '0);
    assign restart  = in_sop && (wr_beat_q != '0);
    // An sop beat is always beat 0, even when it cuts a partial frame short.
    assign eff_beat = in_sop ? '0 : wr_beat_q;
    assign wr_ok    = wr_fire && !drop;

    always_comb begin
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        full_d    = full_q;
        wr_beat_d = wr_beat_q;
        rd_beat_d = rd_beat_q;
        err_d     = 1'b0;

        if (rd_fire) begin
            if (rd_beat_q == LAST_BEAT) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                rd_beat_d        = '0;
            end else begin
                rd_beat_d = rd_beat_q + 1'b1;
            end
        end

        // A completing write never targets the bank being drained, so the
        // two full_d updates touch different bits.
        if (wr_fire) begin
            if (drop) begin
                err_d = 1'b1;
            end else begin
                err_d = restart;
                if (eff_beat == LAST_BEAT) begin
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = !wr_sel_q;
                    wr_beat_d        = '0;
                end else begin
                    wr_beat_d = eff_beat + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            full_q    <= '0;
            wr_beat_q <= '0;
            rd_beat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            full_q    <= full_d;
            wr_beat_q <= wr_beat_d;
            rd_beat_q <= rd_beat_d;
            err_q     <= err_d;
        end
    end

    logic [LANES-1:0][IDX_W-1:0] wr_idx;
    logic [LANES-1:0]            wr_en0, wr_en1;
    beat_t                       wr_data, rd_data0, rd_data1;

    assign wr_data = beat_t'(in_data);

    always_comb begin
        wr_idx = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_idx[l] = bitrev4({eff_beat, BEAT_W'(l)});
        end
    end

    assign wr_en0 = {LANES{wr_ok && !wr_sel_q}};
    assign wr_en1 = {LANES{wr_ok &&  wr_sel_q}};

    fft_reorder_bank u_bank0 (
        .clk       (clk),
        .wr_en_i   (wr_en0),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_beat_i (rd_beat_q),
        .rd_data_o (rd_data0)
    );

    fft_reorder_bank u_bank1 (
        .clk       (clk),
        .wr_en_i   (wr_en1),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_beat_i (rd_beat_q),
        .rd_data_o (rd_data1)
    );

    assign out_data = out_valid ? (rd_sel_q ? rd_data1 : rd_data0) : '0;

`ifdef FFT_REORDER_FRAMECNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = (rd_fire && (rd_beat_q == LAST_BEAT)) ? frame_cnt_q + 16'd1
                                                              : frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder. Sample n of frame f carries
// re = 16*f + n, im = n, so frames and positions are distinguishable.
module tb_fft_out_reorder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sop = 1'b0;
    logic [135:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [135:0] out_data;
    logic         out_last;
    logic         err_sync;
`ifdef FFT_REORDER_FRAMECNT_EN
    logic [15:0]  frame_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // bit-reversed 4-bit index table, written out by hand
    int brv [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;

    fft_out_reorder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_sync  (err_sync)
`ifdef FFT_REORDER_FRAMECNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    function automatic logic [33:0] smp(input int f, input int n);
        logic [16:0] re;
        logic [16:0] im;
        re = 17'(f * 16 + n);
        im = 17'(n);
        return {re, im};
    endfunction

    function automatic logic [135:0] mk_in(input int f, input int b);
        logic [135:0] d;
        d = '0;
        for (int l = 0; l < 4; l++) d[34*l +: 34] = smp(f, brv[4*b + l]);
        return d;
    endfunction

    function automatic logic [135:0] mk_out(input int f, input int k);
        logic [135:0] d;
        d = '0;
        for (int j = 0; j < 4; j++) d[34*j +: 34] = smp(f, 4*k + j);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic push(input int f, input int b, input logic sop);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = mk_in(f, b);
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) chk("push_timeout", {135'd0, in_ready}, 136'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic push_frame(input int f);
        for (int b = 0; b < 4; b++) push(f, b, b == 0);
    endtask

    // Called at a negedge; checks one output beat and accepts it.
    task automatic pull(input int f, input int k);
        int t;
        t = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("pull_valid", {135'd0, out_valid}, 136'd1);
        chk($sformatf("data_f%0d_b%0d", f, k), out_data, mk_out(f, k));
        chk($sformatf("last_f%0d_b%0d", f, k), {135'd0, out_last}, {135'd0, k == 3});
        @(negedge clk);
    endtask

    task automatic pull_frame(input int f);
        for (int k = 0; k < 4; k++) pull(f, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  {135'd0, in_ready},  136'd1);
        chk("rst_out_valid", {135'd0, out_valid}, 136'd0);
        chk("rst_out_data",  out_data, 136'd0);
        chk("rst_out_last",  {135'd0, out_last},  136'd0);
        chk("rst_err_sync",  {135'd0, err_sync},  136'd0);
`ifdef FFT_REORDER_FRAMECNT_EN
        chk("rst_frame_cnt", {120'd0, frame_cnt}, 136'd0);
`endif

        // 2. single frame, latency and ordering
        push(0, 0, 1'b1);
        push(0, 1, 1'b0);
        push(0, 2, 1'b0);
        chk("lat_before", {135'd0, out_valid}, 136'd0);
        push(0, 3, 1'b0);
        chk("lat_after", {135'd0, out_valid}, 136'd1);
        chk("no_err_frame", {135'd0, err_sync}, 136'd0);
        pull_frame(0);
        chk("empty_after_f0", {135'd0, out_valid}, 136'd0);
        chk("zero_data_idle", out_data, 136'd0);

        // 3. back-to-back frames with backpressure
        out_ready = 1'b0;
        push_frame(1);
        chk("ready_after_f1", {135'd0, in_ready}, 136'd1);
        push_frame(2);
        chk("ready_both_full", {135'd0, in_ready}, 136'd0);
        repeat (3) @(negedge clk);
        chk("hold_last", {135'd0, out_last}, 136'd0);
        chk("hold_data", out_data, mk_out(1, 0));
        fork
            push_frame(3);
            begin
                pull_frame(1);
                pull_frame(2);
                pull_frame(3);
            end
        join
        chk("empty_after_f3", {135'd0, out_valid}, 136'd0);

        // 4. framing errors
        push(4, 0, 1'b1);
        push(4, 1, 1'b0);
        push(5, 0, 1'b1);
        chk("err_restart", {135'd0, err_sync}, 136'd1);
        @(negedge clk);
        chk("err_restart_pulse", {135'd0, err_sync}, 136'd0);
        push(5, 1, 1'b0);
        push(5, 2, 1'b0);
        push(5, 3, 1'b0);
        pull_frame(5);
        push(6, 1, 1'b0);
        chk("err_drop", {135'd0, err_sync}, 136'd1);
        @(negedge clk);
        chk("err_drop_pulse", {135'd0, err_sync}, 136'd0);
        push_frame(6);
        pull_frame(6);

        // 5. reset mid-input and mid-output
        out_ready = 1'b0;
        push(7, 0, 1'b1);
        push(7, 1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_valid", {135'd0, out_valid}, 136'd0);
        chk("rst_in_ready2", {135'd0, in_ready}, 136'd1);
        push_frame(8);
        pull(8, 0);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid2", {135'd0, out_valid}, 136'd0);
        chk("rst_in_ready3", {135'd0, in_ready}, 136'd1);
        chk("rst_out_data2", out_data, 136'd0);
        push_frame(9);
        pull_frame(9);

`ifdef FFT_REORDER_FRAMECNT_EN
        // 6. frame counter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 10; f < 13; f++) begin
            push_frame(f);
            pull_frame(f);
        end
        chk("frame_cnt_3", {120'd0, frame_cnt}, 136'd3);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        push_frame(13);
        pull_frame(13);
        chk("frame_cnt_wrap", {120'd0, frame_cnt}, 136'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
